// File: rtl/axi4_burst_mem_slave.sv
// AXI4 memory target with FIXED/INCR/WRAP bursts, byte strobes, ID echo and SLVERR.
// Read and write paths are independent FSMs, each holding one outstanding burst.
module axi4_burst_mem_slave #(
  parameter int unsigned N     = 4,
  parameter int unsigned I     = 1,
  parameter int unsigned DEPTH = 256
) (
  input  logic           ACLK,
  input  logic           ARESET,
  input  logic [I-1:0]   AWID,
  input  logic [31:0]    AWADDR,
  input  logic [7:0]     AWLEN,
  input  logic [2:0]     AWSIZE,
  input  logic [1:0]     AWBURST,
  input  logic           AWVALID,
  output logic           AWREADY,
  input  logic [8*N-1:0] WDATA,
  input  logic [N-1:0]   WSTRB,
  input  logic           WLAST,
  input  logic           WVALID,
  output logic           WREADY,
  output logic [I-1:0]   BID,
  output logic [1:0]     BRESP,
  output logic           BVALID,
  input  logic           BREADY,
  input  logic [I-1:0]   ARID,
  input  logic [31:0]    ARADDR,
  input  logic [7:0]     ARLEN,
  input  logic [2:0]     ARSIZE,
  input  logic [1:0]     ARBURST,
  input  logic           ARVALID,
  output logic           ARREADY,
  output logic [I-1:0]   RID,
  output logic [8*N-1:0] RDATA,
  output logic [1:0]     RRESP,
  output logic           RLAST,
  output logic           RVALID,
  input  logic           RREADY
);

  localparam int unsigned DW    = 8 * N;
  localparam int unsigned NB    = $clog2(N);
  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LIMIT = 32'(DEPTH * N);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [1:0]  B_INCR = 2'b01;
  localparam logic [1:0]  B_WRAP = 2'b10;

  typedef struct packed {
    logic [I-1:0] id;
    logic [31:0]  addr;
    logic [7:0]   len;
    logic [2:0]   size;
    logic [1:0]   burst;
  } req_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  // Address of the following beat; reserved burst type behaves as FIXED.
  function automatic logic [31:0] next_addr(input req_t r);
    logic [31:0] bytes;
    logic [31:0] wlen;
    logic [31:0] nxt;
    bytes = 32'd1 << r.size;
    wlen  = bytes * (32'(r.len) + 32'd1);
    nxt   = r.addr + bytes;
    case (r.burst)
      B_INCR:  next_addr = (r.addr & ~(bytes - 32'd1)) + bytes;
      B_WRAP:  next_addr = (r.addr & ~(wlen - 32'd1)) | (nxt & (wlen - 32'd1));
      default: next_addr = r.addr;
    endcase
  endfunction

  // Errors that poison every beat of a burst.
  function automatic logic burst_err(input req_t r);
    logic bad_wrap;
    bad_wrap  = (r.burst == B_WRAP) && !(r.len inside {8'd1, 8'd3, 8'd7, 8'd15});
    burst_err = (32'(r.size) > NB) || (r.burst == 2'b11) || bad_wrap;
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    word_idx = IW'(a >> NB);
  endfunction

  logic [DW-1:0] mem [DEPTH];

  w_state_e    w_state_q, w_state_d;
  req_t        wreq_q, wreq_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        wberr_q, wberr_d;
  logic        werr_q, werr_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        mem_we;
  logic        w_last;

  r_state_e    r_state_q, r_state_d;
  req_t        rreq_q, rreq_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic        rberr_q, rberr_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;
  logic        ld;
  logic        ld_berr;
  logic        ld_err;
  logic [31:0] ld_addr;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs  = AWVALID && awready_q;
  assign w_hs   = WVALID && wready_q;
  assign b_hs   = BREADY && bvalid_q;
  assign ar_hs  = ARVALID && arready_q;
  assign r_hs   = RREADY && rvalid_q;
  assign w_last = (wcnt_q == wreq_q.len);

  // Write path next state.
  always_comb begin
    w_state_d = w_state_q;
    wreq_d    = wreq_q;
    wcnt_d    = wcnt_q;
    wberr_d   = wberr_q;
    werr_d    = werr_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: if (aw_hs) begin
        wreq_d    = '{id: AWID, addr: AWADDR, len: AWLEN, size: AWSIZE, burst: AWBURST};
        wberr_d   = burst_err(wreq_d);
        werr_d    = 1'b0;
        wcnt_d    = 8'd0;
        w_state_d = W_DATA;
      end
      W_DATA: if (w_hs) begin
        mem_we      = !wberr_q && (wreq_q.addr < LIMIT);
        werr_d      = werr_q || !mem_we || (WLAST != w_last);
        wreq_d.addr = next_addr(wreq_q);
        wcnt_d      = wcnt_q + 8'd1;
        if (w_last) begin
          w_state_d = W_RESP;
          bresp_d   = werr_d ? SLVERR : OKAY;
        end
      end
      W_RESP: if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Read path next state; the beat word is fetched whenever a new address is loaded.
  always_comb begin
    r_state_d = r_state_q;
    rreq_d    = rreq_q;
    rcnt_d    = rcnt_q;
    rberr_d   = rberr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    ld        = 1'b0;
    ld_addr   = rreq_q.addr;
    ld_berr   = rberr_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        rreq_d    = '{id: ARID, addr: ARADDR, len: ARLEN, size: ARSIZE, burst: ARBURST};
        rberr_d   = burst_err(rreq_d);
        rcnt_d    = 8'd0;
        rlast_d   = (ARLEN == 8'd0);
        ld        = 1'b1;
        ld_addr   = ARADDR;
        ld_berr   = rberr_d;
        r_state_d = R_DATA;
      end
      R_DATA: if (r_hs) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
        end else begin
          rreq_d.addr = next_addr(rreq_q);
          rcnt_d      = rcnt_q + 8'd1;
          rlast_d     = (rcnt_d == rreq_q.len);
          ld          = 1'b1;
          ld_addr     = rreq_d.addr;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    ld_err = ld_berr || (ld_addr >= LIMIT);
    if (ld) begin
      rdata_d = ld_err ? '0 : mem[word_idx(ld_addr)];
      rresp_d = ld_err ? SLVERR : OKAY;
    end
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      wreq_q    <= '0;
      wcnt_q    <= '0;
      wberr_q   <= 1'b0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      r_state_q <= R_IDLE;
      rreq_q    <= '0;
      rcnt_q    <= '0;
      rberr_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wreq_q    <= wreq_d;
      wcnt_q    <= wcnt_d;
      wberr_q   <= wberr_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rreq_q    <= rreq_d;
      rcnt_q    <= rcnt_d;
      rberr_q   <= rberr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  // Storage is not reset; a same-cycle read captures the pre-write word.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < N; b++) begin
        if (WSTRB[b]) mem[word_idx(wreq_q.addr)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign BID     = wreq_q.id;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;
  assign RID     = rreq_q.id;

endmodule
